// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

  // Source selected for the next program counter value.
  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_EXC,
    SEL_HOLD
  } pc_sel_t;

  // Widest value sext handles; callers truncate the result to their address width.
  localparam int unsigned SEXT_W = 64;

  // Sign-extend the low 'width' bits of val to SEXT_W bits.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] val,
                                             input int unsigned       width);
    logic signed [SEXT_W-1:0] shifted;
    shifted = $signed(val << (SEXT_W - width));
    return shifted >>> (SEXT_W - width);
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular-buffer return-address stack. A push when full overwrites the
// oldest entry; a pop when empty does nothing. Pop wins over push.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [CNT_W-1:0] count;

  // The slot after the top is also the oldest slot once the buffer is full,
  // so writing there implements drop-oldest for free.
  assign ptr_inc = ptr + PTR_W'(1);

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (pop) begin
      if (count != '0) begin
        ptr   <= ptr - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end else if (push) begin
      ptr <= ptr_inc;
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count gates what is
    // visible, and leaving it out keeps the array mappable to plain flops/RAM.
    if (!reset && !pop && push) mem[ptr_inc] <= push_data;
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: chooses increment, branch, jump, return or
// exception vector each cycle and keeps a return-address stack for calls.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int unsigned           STEP         = 1,
  parameter int unsigned           OFF_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 'h20,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  exception,
  input  logic                  branch_taken,
  input  logic [OFF_WIDTH-1:0]  branch_offset,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_underflow
);

  pc_sel_t               sel;
  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  push;
  logic                  pop;
  logic                  underflow_set;

  // Address arithmetic wraps silently modulo 2^ADDR_WIDTH.
  assign inc       = pc + ADDR_WIDTH'(STEP);
  assign br_target = inc + ADDR_WIDTH'(sext(SEXT_W'(branch_offset), OFF_WIDTH));

  // Priority select: exception > stall > ret > jump > branch > increment.
  always_comb begin
    // NOTE: defaulting every always_comb output first means no path leaves a
    // signal unassigned, so no latch can be inferred.
    sel = SEL_INC;
    if (exception)         sel = SEL_EXC;
    else if (stall)        sel = SEL_HOLD;
    else if (ret)          sel = ras_empty ? SEL_INC : SEL_RET;
    else if (jump)         sel = SEL_JMP;
    else if (branch_taken) sel = SEL_BR;
  end

  // Next-PC mux and stack controls derived from the selected source.
  always_comb begin
    next_pc = inc;
    unique case (sel)
      SEL_INC:  next_pc = inc;
      SEL_BR:   next_pc = br_target;
      SEL_JMP:  next_pc = jump_target;
      SEL_RET:  next_pc = ras_top;
      SEL_EXC:  next_pc = EXC_VECTOR;
      SEL_HOLD: next_pc = pc;
      default:  next_pc = inc;
    endcase
  end

  assign push          = (sel == SEL_JMP) && call;
  assign pop           = (sel == SEL_RET);
  assign underflow_set = !exception && !stall && ret && ras_empty;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // PC register and one-cycle underflow pulse; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= next_pc;
      ras_underflow <= underflow_set;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// return-stack sequences, then random stimulus against a queue-based model.
module tb_pc_sequencer;

  localparam int AW    = 32;
  localparam int OW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, stall, exception, branch_taken, jump, call, ret;
  logic [OW-1:0] branch_offset;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] pc, next_pc;
  logic          ras_empty, ras_full, ras_underflow;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_WIDTH   (AW),
    .STEP         (1),
    .OFF_WIDTH    (OW),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h20),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .pc            (pc),
    .next_pc       (next_pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow)
  );

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        exc;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [31:0] tgt;
    logic        cll;
    logic        rt;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_uf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, return stack as a queue (back = top).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_uf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Apply one cycle of stimulus, check next_pc before the edge and the
  // registered outputs after it, all against the model.
  task automatic step(input stim_t s);
    logic [31:0] inc;
    logic [31:0] exp_next;
    logic signed [31:0] soff;
    reset         = s.rst;
    stall         = s.stl;
    exception     = s.exc;
    branch_taken  = s.br;
    branch_offset = s.off;
    jump          = s.jmp;
    jump_target   = s.tgt;
    call          = s.cll;
    ret           = s.rt;
    #1;
    inc  = m_pc + 32'd1;
    soff = $signed(s.off);
    exp_next = inc;
    if (s.rst) begin
      m_ras.delete();
      m_uf     = 1'b0;
      exp_next = 32'h0;
    end else if (s.exc) begin
      m_uf     = 1'b0;
      exp_next = 32'h20;
    end else if (s.stl) begin
      m_uf     = 1'b0;
      exp_next = m_pc;
    end else if (s.rt) begin
      if (m_ras.size() > 0) begin
        exp_next = m_ras.pop_back();
        m_uf     = 1'b0;
      end else begin
        exp_next = inc;
        m_uf     = 1'b1;
      end
    end else if (s.jmp) begin
      m_uf = 1'b0;
      if (s.cll) begin
        m_ras.push_back(inc);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      exp_next = s.tgt;
    end else if (s.br) begin
      m_uf     = 1'b0;
      exp_next = inc + soff;
    end else begin
      m_uf = 1'b0;
    end
    if (!s.rst) check("next_pc", next_pc, exp_next);
    @(posedge clk);
    #1;
    m_pc = exp_next;
    check("pc", pc, m_pc);
    check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    check("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
    check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
  endtask

  function automatic stim_t mk(input logic r, input logic st, input logic e, input logic b,
                               input logic [15:0] o, input logic j, input logic [31:0] t,
                               input logic c, input logic rt);
    stim_t s;
    s.rst = r; s.stl = st; s.exc = e; s.br = b; s.off = o;
    s.jmp = j; s.tgt = t; s.cll = c; s.rt = rt;
    return s;
  endfunction

  vec_t tbl[$];

  initial begin
    stim_t s;
    m_pc = 32'h0;
    m_uf = 1'b0;

    // Directed table: stimulus plus hand-derived expected pc/empty/underflow.
    //               rst st exc br  off       jmp tgt            call ret        pc          empty uf
    tbl.push_back('{mk(1, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h0,        1, 0});
    tbl.push_back('{mk(1, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h0,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h1,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h2,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h3,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'd10,         0, 0), 32'd10,       1, 0});
    tbl.push_back('{mk(0, 0, 0, 1, 16'hFFFC, 0, 32'h0,          0, 0), 32'd7,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'hFFFF_FFFF,  0, 0), 32'hFFFF_FFFF, 1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h0,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'd5,          0, 0), 32'd5,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'd100,        1, 0), 32'd100,      0, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'd101,      0, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'd102,      0, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'd103,      0, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 1), 32'd6,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'd8,          0, 0), 32'd8,        1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 1), 32'd9,        1, 1});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'd10,       1, 0});
    tbl.push_back('{mk(0, 1, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'd10,       1, 0});
    tbl.push_back('{mk(0, 1, 1, 0, 16'h0,    0, 32'h0,          0, 0), 32'h20,       1, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'd50,         1, 0), 32'd50,       0, 0});
    tbl.push_back('{mk(0, 0, 0, 0, 16'h0,    1, 32'd200,        0, 1), 32'h21,       1, 0});
    tbl.push_back('{mk(0, 1, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h21,       1, 0});
    tbl.push_back('{mk(1, 1, 0, 0, 16'h0,    0, 32'h0,          0, 0), 32'h0,        1, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      check($sformatf("tbl%0d_empty", i), 32'(ras_empty), 32'(tbl[i].exp_empty));
      check($sformatf("tbl%0d_uf", i), 32'(ras_underflow), 32'(tbl[i].exp_uf));
    end

    // Overflow: five calls from pcs 0,10,20,30,40 drop the oldest return (1).
    step(mk(0, 0, 0, 0, 16'h0, 1, 32'd0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 0, 0, 0, 16'h0, 1, 32'((i + 1) * 10), 1, 0));
      if (i >= 3) check($sformatf("ovf_full%0d", i), 32'(ras_full), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 0, 0, 0, 16'h0, 0, 32'h0, 0, 1));
      check($sformatf("ovf_ret%0d", i), pc, 32'(41 - 10 * i));
    end
    check("ovf_empty", 32'(ras_empty), 32'd1);
    // One more return now underflows and falls through to increment (12).
    step(mk(0, 0, 0, 0, 16'h0, 0, 32'h0, 0, 1));
    check("ovf_uf_pc", pc, 32'd12);
    check("ovf_uf_pulse", 32'(ras_underflow), 32'd1);
    step(idle());
    check("ovf_uf_clear", 32'(ras_underflow), 32'd0);

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      s.rst = ($urandom_range(0, 63) == 0);
      s.stl = ($urandom_range(0, 7) == 0);
      s.exc = ($urandom_range(0, 15) == 0);
      s.br  = ($urandom_range(0, 3) == 0);
      s.off = 16'($urandom);
      s.jmp = ($urandom_range(0, 4) == 0);
      s.tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 4095));
      s.cll = $urandom_range(0, 1) == 1;
      s.rt  = ($urandom_range(0, 4) == 0);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
